// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit ripple-carry adder split into STAGES slices,
// one registered carry hop per stage, valid/ready on both sides.
//
// Optional feature: define PIPELINED_ADDER_SUB_EN to add the 'sub' input
// (a - b computed as a + ~b + 1, cin ignored for that operation).
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   in_valid   operands present this cycle
//   in_ready   block can accept this cycle (= !out_valid || out_ready)
//   a, b       operands, WIDTH bits
//   cin        carry-in
//   sub        (PIPELINED_ADDER_SUB_EN only) subtract request
//   out_valid  result present
//   out_ready  consumer accepts result
//   sum        result, WIDTH bits
//   cout       carry-out of bit WIDTH-1 (for subtraction: 1 = no borrow)
//   ovf        signed two's-complement overflow
module pipelined_adder #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef PIPELINED_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CHUNK = (STAGES == 0) ? 1 : WIDTH / STAGES;
  localparam int unsigned CW    = CHUNK + 1;

  // Elaboration-time parameter sanity check.
  if (WIDTH < 1 || STAGES < 1 || (WIDTH % ((STAGES == 0) ? 1 : STAGES)) != 0) begin : g_bad_cfg
    $error("pipelined_adder: WIDTH must be >= 1, STAGES >= 1, WIDTH divisible by STAGES");
  end

  // Per-stage registers: valid, carry out of the slice, delayed operands,
  // and the partial sum with all completed low slices filled in.
  logic             v_q [STAGES];
  logic             c_q [STAGES];
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic             ovf_q;

  // Values presented to each stage's adder slice.
  logic             v_i [STAGES];
  logic             c_i [STAGES];
  logic [WIDTH-1:0] a_i [STAGES];
  logic [WIDTH-1:0] b_i [STAGES];
  logic [WIDTH-1:0] s_i [STAGES];

  // Slice results to be registered by each stage.
  logic [CHUNK:0]   slice [STAGES];
  logic             c_n   [STAGES];
  logic [WIDTH-1:0] s_n   [STAGES];
  logic             ovf_n;

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  // Operand conditioning at the pipeline entry.
`ifdef PIPELINED_ADDER_SUB_EN
  // Subtraction travels down the pipe as an inverted b with a forced +1,
  // so the sub flag rides along with its operands implicitly.
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub | cin;
`else
  assign b_eff   = b;
  assign cin_eff = cin;
`endif

  // Whole pipe advances together unless the output is held.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Stage input views: stage 0 from the ports, stage k from stage k-1.
  always_comb begin
    v_i[0] = in_valid;
    c_i[0] = cin_eff;
    a_i[0] = a;
    b_i[0] = b_eff;
    s_i[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      v_i[k] = v_q[k-1];
      c_i[k] = c_q[k-1];
      a_i[k] = a_q[k-1];
      b_i[k] = b_q[k-1];
      s_i[k] = s_q[k-1];
    end
  end

  // Slice adders: stage k adds bits [k*CHUNK +: CHUNK] with the incoming carry.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      slice[k] = {1'b0, a_i[k][k*CHUNK +: CHUNK]}
               + {1'b0, b_i[k][k*CHUNK +: CHUNK]}
               + CW'(c_i[k]);
      c_n[k]   = slice[k][CHUNK];
      s_n[k]   = s_i[k];
      s_n[k][k*CHUNK +: CHUNK] = slice[k][CHUNK-1:0];
    end
  end

  // Carry into the MSB is recovered as sum ^ a ^ b at that bit.
  always_comb begin
    ovf_n = (s_n[STAGES-1][WIDTH-1] ^ a_i[STAGES-1][WIDTH-1] ^ b_i[STAGES-1][WIDTH-1])
          ^ c_n[STAGES-1];
  end

  // Pipeline registers; data only loads for valid entries so bubbles keep
  // the previous contents (and the outputs) quiet.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= 1'b0;
        c_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
      ovf_q <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= v_i[k];
        if (v_i[k]) begin
          c_q[k] <= c_n[k];
          a_q[k] <= a_i[k];
          b_q[k] <= b_i[k];
          s_q[k] <= s_n[k];
        end
      end
      if (v_i[STAGES-1]) begin
        ovf_q <= ovf_n;
      end
    end
  end

  // Last stage drives the outputs directly.
  assign out_valid = v_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed testbench for pipelined_adder (WIDTH=16, STAGES=4).
// Expected words are {cout, ovf, sum}, computed by hand.
module tb_pipelined_adder;

  localparam int unsigned W = 16;
  localparam int unsigned S = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
`ifdef PIPELINED_ADDER_SUB_EN
  logic         sub;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int n_chk     = 0;
  int n_pass    = 0;
  int n_out     = 0;
  int cyc_n     = 0;
  int out_first = -1;
  int out_last  = -1;

  logic [17:0] expq [$];

  // Directed vectors: a, b, cin, expected {cout, ovf, sum}.
  logic [15:0] ta [8] = '{16'h0001, 16'h00FF, 16'h0FFF, 16'h8000,
                          16'hFFFF, 16'h1234, 16'h7FFF, 16'hA5A5};
  logic [15:0] tb [8] = '{16'h0002, 16'h0001, 16'h0001, 16'h8000,
                          16'hFFFF, 16'h4321, 16'h0001, 16'h5A5A};
  logic        tc [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [17:0] te [8] = '{18'h00003, 18'h00100, 18'h01001, 18'h30000,
                          18'h2FFFF, 18'h05556, 18'h18000, 18'h0FFFF};

  pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef PIPELINED_ADDER_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One clock: drive inputs, score the output about to be consumed, record
  // the accepted operation, then step to just after the next rising edge.
  task automatic cyc(input logic v, input logic [15:0] ia, input logic [15:0] ib,
                     input logic ic, input logic [17:0] e, input logic ordy);
    logic [18:0] want;
    in_valid  = v;
    a         = ia;
    b         = ib;
    cin       = ic;
    out_ready = ordy;
    #1;
    if (out_valid && out_ready) begin
      if (expq.size() == 0) want = 19'h7FFFF;
      else                  want = {1'b0, expq.pop_front()};
      check("result", 32'({cout, ovf, sum}), 32'(want));
      n_out++;
      if (out_first < 0) out_first = cyc_n;
      out_last = cyc_n;
    end
    if (in_valid && in_ready) expq.push_back(e);
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic idle();
    cyc(1'b0, 16'h0000, 16'h0000, 1'b0, 18'h0, 1'b1);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && expq.size() > 0; i++) idle();
    check("drain_empty", 32'(expq.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
`ifdef PIPELINED_ADDER_SUB_EN
    sub = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum",       32'(sum),       32'd0);
    check("rst_cout",      32'(cout),      32'd0);
    check("rst_ovf",       32'(ovf),       32'd0);
    rst = 1'b0;
    #1;
    check("rst_in_ready",  32'(in_ready),  32'd1);

    // Carry ripples across every slice; result on the 4th edge.
    cyc(1'b1, 16'hFFFF, 16'h0001, 1'b0, 18'h20000, 1'b1);
    for (int e = 1; e <= 4; e++) begin
      check("lat_valid", 32'(out_valid), 32'(e == S));
      if (e < S) idle();
    end
    check("lat_sum",  32'(sum),  32'h0000);
    check("lat_cout", 32'(cout), 32'd1);
    check("lat_ovf",  32'(ovf),  32'd0);
    drain();

    // Back-to-back streaming.
    n_out = 0; out_first = -1; out_last = -1;
    for (int i = 0; i < 8; i++) begin
      check("stream_in_ready", 32'(in_ready), 32'd1);
      cyc(1'b1, ta[i], tb[i], tc[i], te[i], 1'b1);
    end
    drain();
    check("stream_count", 32'(n_out), 32'd8);
    check("stream_span",  32'(out_last - out_first), 32'd7);

    // Backpressure on a full pipe.
    n_out = 0;
    for (int i = 0; i < 4; i++) cyc(1'b1, ta[i], tb[i], tc[i], te[i], 1'b1);
    check("bp_full", 32'(out_valid), 32'd1);
    for (int s = 0; s < 3; s++) begin
      cyc(1'b1, ta[4], tb[4], tc[4], te[4], 1'b0);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_valid",    32'(out_valid), 32'd1);
      check("bp_hold",     32'({cout, ovf, sum}), 32'(te[0]));
    end
    for (int i = 4; i < 8; i++) cyc(1'b1, ta[i], tb[i], tc[i], te[i], 1'b1);
    drain();
    check("bp_count", 32'(n_out), 32'd8);

    // Reset with three operations in flight; input during reset is dropped.
    n_out = 0;
    for (int i = 0; i < 3; i++) cyc(1'b1, ta[i], tb[i], tc[i], te[i], 1'b1);
    rst = 1'b1;
    cyc(1'b1, ta[3], tb[3], tc[3], te[3], 1'b1);
    rst = 1'b0;
    expq.delete();
    check("rstm_valid",    32'(out_valid), 32'd0);
    check("rstm_sum",      32'(sum),       32'd0);
    check("rstm_cout",     32'(cout),      32'd0);
    check("rstm_ovf",      32'(ovf),       32'd0);
    check("rstm_in_ready", 32'(in_ready),  32'd1);
    for (int i = 0; i < 8; i++) begin
      idle();
      check("rstm_no_stale", 32'(out_valid), 32'd0);
    end
    check("rstm_count", 32'(n_out), 32'd0);
    cyc(1'b1, 16'h7FFF, 16'h0001, 1'b0, 18'h18000, 1'b1);
    drain();
    check("post_rst_count", 32'(n_out), 32'd1);

`ifdef PIPELINED_ADDER_SUB_EN
    // Subtraction; cin is ignored when sub=1.
    n_out = 0;
    sub = 1'b1;
    cyc(1'b1, 16'h0005, 16'h0007, 1'b0, 18'h0FFFE, 1'b1);
    cyc(1'b1, 16'h8000, 16'h0001, 1'b1, 18'h37FFF, 1'b1);
    sub = 1'b0;
    cyc(1'b1, 16'h1234, 16'h4321, 1'b1, 18'h05556, 1'b1);
    drain();
    check("sub_count", 32'(n_out), 32'd3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined ripple-carry adder; the sequential successor to the single-bit full adder.
- Splits a WIDTH-bit add into STAGES slices, with one registered carry hop per stage. Supports a throughput of one operation per clock.
- Valid/ready handshake on both sides, so it drops into datapaths that apply backpressure.
- Reports carry-out and signed overflow.

Parameters:
- WIDTH, 16, operand and sum width in bits; must be ≥ 1.
- STAGES, 4, number of pipeline stages; WIDTH must be divisible by STAGES; must be ≥ 1. Violation is an elaboration-time error.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  operands present this cycle
- in_ready  output  1  block can accept this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result
- cout  output  1  carry-out of bit WIDTH-1
- ovf  output  1  signed (two's complement) overflow

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high.
- Slicing: CHUNK = WIDTH/STAGES.
  - Stage k adds slice k of a/b using the carry registered by stage k-1; stage 0 uses cin.
  - Operand slices for later stages are delay-registered so they arrive with their carry.
  - Completed low slices are delay-registered so that all slices reach the output register together (deskew).
- Each stage holds a valid bit. The last stage's registers drive out_valid, sum, cout and ovf directly; no combinational path from a/b to the outputs.
- Advance rule: adv = !out_valid || out_ready.
  - in_ready = adv.
  - When adv=1, every stage shifts one position.
  - When adv=0, every stage holds, including data and valid.
- Accept: a transfer occurs on a rising edge with in_valid && in_ready.
  - If in_valid=0 while adv=1, a bubble (valid=0) enters stage 0.
- Latency: the result is visible on the outputs after STAGES rising edges, counting the accepting edge, provided no stall occurs. STAGES=1 gives a single registered add.
- Throughput: 1 result/cycle while out_ready=1. Results emerge strictly in acceptance order.
- Stall: while out_valid=1 && out_ready=0:
  - sum, cout and ovf are held stable;
  - no in-flight operation is lost or duplicated;
  - in_ready=0.
- Arithmetic:
  - {cout,sum} = a + b + cin, computed modulo 2^(WIDTH+1).
  - ovf = carry into bit WIDTH-1 XOR cout.
- Reset:
  - all stage valid bits = 0, out_valid = 0, sum = 0, cout = 0, ovf = 0, all internal carry and delay registers = 0;
  - in_ready = 1 in the first cycle after reset deasserts.
  - Reset mid-operation discards every in-flight operation; none appears afterwards.
  - rst has priority over handshake activity in the same cycle.
- Simultaneous accept and drain in one cycle (out_valid && out_ready && in_valid): both happen, and the pipeline stays full.
- Wrap-around: a = all-ones, b = 1 gives sum = 0, cout = 1. No saturation.

Optional Feature:
- Macro: PIPELINED_ADDER_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), sampled together with a/b at acceptance.
  - sub=1 computes a - b as a + ~b + 1; cin is ignored for that operation.
  - cout=1 means no borrow.
  - ovf follows the same signed rule as for addition.
  - sub is carried through the pipeline with its operands.
- Undefined: port sub does not exist and the block only adds.

Test Plan (WIDTH=16, STAGES=4):
- Carry across every stage boundary: a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, ovf=0, out_valid on the 4th edge counting the accepting edge.
- Signed overflow: a=0x7FFF, b=0x0001, cin=0 → sum=0x8000, cout=0, ovf=1. Also a=0x1234, b=0x4321, cin=1 → sum=0x5556, cout=0, ovf=0.
- Streaming: 8 back-to-back random operations with out_ready=1 → 8 results on consecutive cycles, in order, each matching a+b+cin; in_ready stays 1.
- Backpressure: fill the pipeline, hold out_ready=0 for 3 cycles → in_ready=0, sum/cout/ovf stable; after release, all results arrive in order with none lost or duplicated.
- Reset mid-flight: accept 3 operations, assert rst for 1 cycle → out_valid=0 and sum=0 the cycle after; no stale result ever appears.
- With PIPELINED_ADDER_SUB_EN defined: a=0x0005, b=0x0007, sub=1 → sum=0xFFFE, cout=0, ovf=0. Also a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, cout=1, ovf=1.
